decode_hazard_ctrl: RTL and testbench

Load-use interlock and stall scheduler for the decode stage. It keeps a per-register scoreboard of destinations of issued loads that have not yet written back, and drives `stall_decode` whenever the instruction in decode reads such a register. It also stalls when the outstanding-load budget is exhausted or the cache back-pressures. It sits beside `decode_top`, fed by the fetched instruction fields and by the writeback port of the register file.

---
 rtl/decode_hazard_if.sv | 37 +++
 rtl/decode_hazard_ctrl.sv | 76 +++++++
 tb/tb_decode_hazard_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_hazard_if.sv
// Decode-stage hazard bus: instruction fields and writeback port in, stall/issue and scoreboard state out.
interface decode_hazard_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LD   = 2,
    parameter int CNT_W    = 16
);
    localparam int LDC_W = $clog2(MAX_LD + 1);

    logic                instr_valid;
    logic [ADDR_W-1:0]   src1_addr;
    logic [ADDR_W-1:0]   src2_addr;
    logic                src2_used;
    logic [ADDR_W-1:0]   dst_addr;
    logic                is_load;
    logic                cache_busy;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic                flush;
    logic                stall_decode;
    logic                issue;
    logic [NUM_REGS-1:0] pending;
    logic [LDC_W-1:0]    ld_outstanding;
    logic [CNT_W-1:0]    stall_cycles;

    modport master (
        output instr_valid, src1_addr, src2_addr, src2_used, dst_addr, is_load,
               cache_busy, wb_valid, wb_addr, flush,
        input  stall_decode, issue, pending, ld_outstanding, stall_cycles
    );

    modport slave (
        input  instr_valid, src1_addr, src2_addr, src2_used, dst_addr, is_load,
               cache_busy, wb_valid, wb_addr, flush,
        output stall_decode, issue, pending, ld_outstanding, stall_cycles
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Load-use interlock for decode: per-register scoreboard of outstanding loads,
// load budget counter and saturating stall-cycle counter.
module decode_hazard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LD   = 2,
    parameter int CNT_W    = 16
) (
    input logic             clock,
    input logic             reset,
    decode_hazard_if.slave  hz
);
    localparam int LDC_W = $clog2(MAX_LD + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [LDC_W-1:0]    ld_q, ld_d;
    logic [CNT_W-1:0]    stall_q;

    logic raw1, raw2, waw, full, bp, hazard;
    logic stall, issue, ld_issue, wb_hit;

    // Hazards look only at registered state, so a same-cycle writeback
    // releases its reader one cycle later, when the RF write is visible.
    always_comb begin
        raw1   = pending_q[hz.src1_addr];
        raw2   = hz.src2_used & pending_q[hz.src2_addr];
        waw    = hz.is_load & pending_q[hz.dst_addr];
        full   = hz.is_load & (ld_q == LDC_W'(MAX_LD));
        bp     = hz.is_load & hz.cache_busy;
        hazard = raw1 | raw2 | waw | full | bp;
        stall  = hz.instr_valid & ~hz.flush & hazard;
        issue  = hz.instr_valid & ~hz.flush & ~stall;
    end

    assign ld_issue = issue & hz.is_load;
    assign wb_hit   = hz.wb_valid & pending_q[hz.wb_addr];

    // Per-register next state: flush, then load set over writeback clear.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        logic set_r, clr_r;
        assign set_r = ld_issue && (hz.dst_addr == ADDR_W'(r));
        assign clr_r = hz.wb_valid && (hz.wb_addr == ADDR_W'(r));
        assign pending_d[r] = hz.flush ? 1'b0 :
                              set_r    ? 1'b1 :
                              clr_r    ? 1'b0 : pending_q[r];
    end

    always_comb begin
        ld_d = ld_q;
        if (hz.flush)
            ld_d = '0;
        else if (ld_issue && !wb_hit && ld_q != LDC_W'(MAX_LD))
            ld_d = ld_q + 1'b1;
        else if (wb_hit && !ld_issue && ld_q != '0)
            ld_d = ld_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            ld_q      <= '0;
            stall_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ld_q      <= ld_d;
            if (stall && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign hz.stall_decode   = stall;
    assign hz.issue          = issue;
    assign hz.pending        = pending_q;
    assign hz.ld_outstanding = ld_q;
    assign hz.stall_cycles   = stall_q;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl (CNT_W=4 so stall-counter saturation is reachable).
module tb_decode_hazard_ctrl;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_LD   = 2;
    localparam int CNT_W    = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    decode_hazard_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .MAX_LD(MAX_LD), .CNT_W(CNT_W)) bus ();

    decode_hazard_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .MAX_LD(MAX_LD), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.src1_addr   = '0;
        bus.src2_addr   = '0;
        bus.src2_used   = 1'b0;
        bus.dst_addr    = '0;
        bus.is_load     = 1'b0;
        bus.cache_busy  = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic load(input logic [4:0] dst, input logic [4:0] s1);
        idle();
        bus.instr_valid = 1'b1;
        bus.is_load     = 1'b1;
        bus.dst_addr    = dst;
        bus.src1_addr   = s1;
    endtask

    task automatic alu(input logic [4:0] s1, input logic [4:0] s2, input logic s2u, input logic [4:0] dst);
        idle();
        bus.instr_valid = 1'b1;
        bus.src1_addr   = s1;
        bus.src2_addr   = s2;
        bus.src2_used   = s2u;
        bus.dst_addr    = dst;
    endtask

    initial begin
        idle();
        #12;
        chk("rst_stall", 32'(bus.stall_decode), 0);
        chk("rst_issue", 32'(bus.issue), 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_ld", 32'(bus.ld_outstanding), 0);
        chk("rst_cnt", 32'(bus.stall_cycles), 0);
        reset = 1'b1;
        tick();

        // Load-use on r5: stalls cycles 2-4, wb at 4, issue at 5
        load(5'd5, 5'd0); #1;
        chk("lu_ld_issue", 32'(bus.issue), 1);
        tick();
        alu(5'd5, 5'd6, 1'b1, 5'd9); #1;
        chk("lu_c2_stall", 32'(bus.stall_decode), 1);
        chk("lu_c2_pend", bus.pending, 32'h20);
        chk("lu_c2_ld", 32'(bus.ld_outstanding), 1);
        tick();
        chk("lu_c3_stall", 32'(bus.stall_decode), 1);
        tick();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; #1;
        chk("lu_c4_stall", 32'(bus.stall_decode), 1);
        chk("lu_c4_issue", 32'(bus.issue), 0);
        tick();
        bus.wb_valid = 1'b0; #1;
        chk("lu_c5_issue", 32'(bus.issue), 1);
        chk("lu_c5_stall", 32'(bus.stall_decode), 0);
        chk("lu_c5_cnt", 32'(bus.stall_cycles), 3);
        chk("lu_c5_pend", bus.pending, 0);
        chk("lu_c5_ld", 32'(bus.ld_outstanding), 0);
        tick();

        // Load budget: r1, r2 issue, r3 stalls while full
        load(5'd1, 5'd0); #1;
        chk("mx_r1_issue", 32'(bus.issue), 1);
        tick();
        load(5'd2, 5'd0); #1;
        chk("mx_r2_issue", 32'(bus.issue), 1);
        tick();
        load(5'd3, 5'd0); #1;
        chk("mx_r3_stall", 32'(bus.stall_decode), 1);
        chk("mx_ld2", 32'(bus.ld_outstanding), 2);
        chk("mx_pend", bus.pending, 32'h6);
        tick();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd1; #1;
        chk("mx_wb_stall", 32'(bus.stall_decode), 1);
        tick();
        bus.wb_valid = 1'b0; #1;
        chk("mx_r3_issue", 32'(bus.issue), 1);
        chk("mx_ld1", 32'(bus.ld_outstanding), 1);
        chk("mx_cnt", 32'(bus.stall_cycles), 5);
        tick();
        idle(); #1;
        chk("mx_ld_back2", 32'(bus.ld_outstanding), 2);
        chk("mx_pend2", bus.pending, 32'hC);

        // Writeback and load issue in the same cycle
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd2;
        tick();
        load(5'd7, 5'd0);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; #1;
        chk("sc_issue", 32'(bus.issue), 1);
        tick();
        idle(); #1;
        chk("sc_pend", bus.pending, 32'h80);
        chk("sc_ld", 32'(bus.ld_outstanding), 1);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd20;
        tick();
        idle(); #1;
        chk("sc_stray_wb_ld", 32'(bus.ld_outstanding), 1);
        load(5'd7, 5'd0); #1;
        chk("sc_waw_stall", 32'(bus.stall_decode), 1);
        tick();
        chk("sc_cnt", 32'(bus.stall_cycles), 6);

        // Flush with two loads outstanding
        load(5'd8, 5'd0); #1;
        chk("fl_r8_issue", 32'(bus.issue), 1);
        tick();
        load(5'd9, 5'd0);
        bus.flush = 1'b1; #1;
        chk("fl_stall", 32'(bus.stall_decode), 0);
        chk("fl_issue", 32'(bus.issue), 0);
        tick();
        idle(); #1;
        chk("fl_pend", bus.pending, 0);
        chk("fl_ld", 32'(bus.ld_outstanding), 0);
        chk("fl_cnt_kept", 32'(bus.stall_cycles), 6);
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd1;
        tick();
        idle(); #1;
        chk("fl_late_wb_ld", 32'(bus.ld_outstanding), 0);

        // Register 0 is tracked like any other
        load(5'd0, 5'd0);
        tick();
        alu(5'd0, 5'd0, 1'b0, 5'd11); #1;
        chk("r0_stall", 32'(bus.stall_decode), 1);
        chk("r0_pend", bus.pending, 32'h1);
        tick();
        idle();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0;
        tick();
        idle(); #1;
        chk("r0_clear", bus.pending, 0);

        // src2_used gates raw2
        load(5'd4, 5'd0);
        tick();
        alu(5'd1, 5'd4, 1'b0, 5'd12); #1;
        chk("s2_unused_stall", 32'(bus.stall_decode), 0);
        chk("s2_unused_issue", 32'(bus.issue), 1);
        bus.src2_used = 1'b1; #1;
        chk("s2_used_stall", 32'(bus.stall_decode), 1);
        tick();
        chk("s2_cnt", 32'(bus.stall_cycles), 8);

        // Hold the stall 20 cycles: counter saturates
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(bus.stall_decode), 1);
        chk("sat_cnt", 32'(bus.stall_cycles), 15);
        tick();
        chk("sat_hold", 32'(bus.stall_cycles), 15);

        // Async reset mid-operation; later writeback ignored
        reset = 1'b0; #1;
        chk("mr_pend", bus.pending, 0);
        chk("mr_ld", 32'(bus.ld_outstanding), 0);
        chk("mr_cnt", 32'(bus.stall_cycles), 0);
        idle(); #2;
        reset = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd4;
        tick();
        idle(); #1;
        chk("mr_late_wb_ld", 32'(bus.ld_outstanding), 0);

        // Cache back-pressure blocks loads only
        load(5'd10, 5'd0);
        bus.cache_busy = 1'b1; #1;
        chk("bp_stall", 32'(bus.stall_decode), 1);
        alu(5'd1, 5'd2, 1'b1, 5'd3);
        bus.cache_busy = 1'b1; #1;
        chk("bp_alu_issue", 32'(bus.issue), 1);
        load(5'd10, 5'd0); #1;
        chk("bp_release", 32'(bus.issue), 1);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
